// File: rtl/follower_pkg.sv
// Shared types, channel map and saturation helper for the line-follower datapath.
package follower_pkg;

  localparam int ACC_W = 17;

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, ACCUM, DONE} err_state_t;

  // Index 0 sits in the LSBs: inner pair first, outer pair last, right before left.
  localparam logic [7:0][2:0] CH_MAP = {3'd6, 3'd7, 3'd5, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

  localparam logic signed [ACC_W-1:0] SAT_MAX = 1023;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -1024;

  function automatic logic [10:0] sat11(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      sat11 = 11'h3FF;
    else if (a < SAT_MIN) sat11 = 11'h400;
    else                  sat11 = a[10:0];
  endfunction

endpackage

// File: rtl/settle_tmr.sv
// Loadable up-counter; tc flags the last count of an N-clock interval.
module settle_tmr #(
  parameter int N = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(N) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == W'(N - 1));

endmodule

// File: rtl/err_compute.sv
// Sequences 8 A2D conversions after IR settle, forms the weighted right-minus-left
// error, saturates it to 11 bits and strobes err_vld once per measurement.
module err_compute
  import follower_pkg::*;
#(
  parameter int          SETTLE_CYC = 4096,
  parameter logic [11:0] LINE_THRES = 12'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  output logic        IR_en,
  output logic [2:0]  chnnl,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [10:0] err_sat,
  output logic        err_vld,
  output logic        line_present
);

  err_state_t state, nxt;

  logic                    start;
  logic                    tc;
  logic [2:0]              idx;
  logic [11:0]             res_q;
  logic                    flag;
  logic signed [ACC_W-1:0] acc;
  logic        [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] term;

  assign start = (state == IDLE) && go;

  settle_tmr #(.N(SETTLE_CYC)) u_tmr (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (state == SETTLE),
    .tc  (tc)
  );

  // Zero-extend before shifting so the outer-pair weight never loses bits.
  assign ext  = ACC_W'(res_q);
  assign term = ext << idx[2:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go) nxt = SETTLE;
      SETTLE:  if (tc) nxt = CONV;
      CONV:    nxt = WAIT;
      WAIT:    if (cnv_cmplt) nxt = ACCUM;
      ACCUM:   nxt = (idx == 3'd7) ? DONE : CONV;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    strt_cnv = (state == CONV);
    chnnl    = 3'd0;
    if (state == CONV || state == WAIT) chnnl = CH_MAP[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IR_en        <= 1'b0;
      acc          <= '0;
      idx          <= '0;
      res_q        <= '0;
      flag         <= 1'b0;
      err_sat      <= '0;
      err_vld      <= 1'b0;
      line_present <= 1'b0;
    end else begin
      err_vld <= (state == DONE);
      case (state)
        IDLE: if (go) begin
          IR_en <= 1'b1;
          acc   <= '0;
          idx   <= '0;
          flag  <= 1'b0;
        end
        WAIT: if (cnv_cmplt) res_q <= res;
        ACCUM: begin
          // Even idx is a right sensor, odd idx its left partner.
          acc  <= idx[0] ? acc - term : acc + term;
          flag <= flag | (res_q >= LINE_THRES);
          if (idx != 3'd7) idx <= idx + 3'd1;
        end
        DONE: begin
          err_sat      <= sat11(acc);
          line_present <= flag;
          IR_en        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_err_compute.sv
// Directed bench for err_compute with a behavioural A2D model.
module tb_err_compute;

  localparam int SETTLE  = 16;
  localparam int A2D_LAT = 5;
  localparam int LAT_EXP = 1 + SETTLE + 8 * (3 + A2D_LAT) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic        IR_en;
  logic [2:0]  chnnl;
  logic        strt_cnv;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic [10:0] err_sat;
  logic        err_vld;
  logic        line_present;

  err_compute #(.SETTLE_CYC(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .IR_en        (IR_en),
    .chnnl        (chnnl),
    .strt_cnv     (strt_cnv),
    .cnv_cmplt    (cnv_cmplt),
    .res          (res),
    .err_sat      (err_sat),
    .err_vld      (err_vld),
    .line_present (line_present)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus-side controls (main process only)
  logic [11:0] res_tab [8];
  int          lat      = A2D_LAT;
  int          spur_req = 0;

  // observation state (model process only)
  int          spur_ack = 0;
  int          cd       = 0;
  logic [2:0]  pend_ch  = '0;
  int          strt_cnt = 0;
  int          vld_cnt  = 0;
  int          viol     = 0;
  int          hold_err = 0;
  int          last_vld = 0;
  int          prev_vld = 0;
  logic [10:0] last_err = '0;
  logic        last_lp  = 1'b0;
  logic        vld_d    = 1'b0;
  logic        ir_after = 1'b1;
  logic [2:0]  ch_q [$];

  int nvec = 0;
  int nerr = 0;

  // A2D: cnv_cmplt arrives lat+1 clocks after the strt_cnv clock.
  initial begin
    for (int k = 0; k < 8; k++) res_tab[k] = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (vld_d) ir_after = IR_en;
      vld_d = err_vld;
      if (err_vld) begin
        vld_cnt++;
        prev_vld = last_vld;
        last_vld = cyc;
        last_err = err_sat;
        last_lp  = line_present;
      end
      if (rst) cd = 0;
      if (spur_req != spur_ack) begin
        spur_ack  = spur_req;
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
      end else if (strt_cnv) begin
        if (cd > 0) viol++;
        cd      = lat + 1;
        pend_ch = chnnl;
        ch_q.push_back(chnnl);
        strt_cnt++;
      end else if (cd > 0) begin
        if (chnnl != pend_ch) hold_err++;
        cd--;
        if (cd == 0) begin
          cnv_cmplt = 1'b1;
          res       = res_tab[pend_ch];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_res(input logic [11:0] c0, c1, c2, c3, c4, c5, c6, c7);
    res_tab[0] = c0; res_tab[1] = c1; res_tab[2] = c2; res_tab[3] = c3;
    res_tab[4] = c4; res_tab[5] = c5; res_tab[6] = c6; res_tab[7] = c7;
  endtask

  task automatic wait_vld(input string tag, input int target);
    for (int i = 0; i < 3000 && vld_cnt < target; i++) tick();
    chk({tag, " vld_seen"}, vld_cnt, target);
  endtask

  task automatic wait_strt(input string tag, input int target);
    for (int i = 0; i < 3000 && strt_cnt < target; i++) tick();
    chk({tag, " strt_seen"}, strt_cnt, target);
  endtask

  task automatic run_cycle(input string tag, input logic [10:0] e_err, input logic e_lp,
                           input bit chk_lat, input bit spur);
    int b_v, b_s, b_viol, c0;
    tick();
    b_v = vld_cnt; b_s = strt_cnt; b_viol = viol;
    go = 1'b1;
    c0 = cyc;
    tick();
    go = 1'b0;
    if (spur) begin
      repeat (4) tick();
      spur_req++;
    end
    wait_vld(tag, b_v + 1);
    chk({tag, " err_sat"}, err_sat, e_err);
    chk({tag, " line"}, last_lp, e_lp);
    chk({tag, " strt_cnt"}, strt_cnt - b_s, 8);
    chk({tag, " viol"}, viol - b_viol, 0);
    if (chk_lat) chk({tag, " latency"}, last_vld - c0, LAT_EXP);
    tick();
    chk({tag, " ir_after"}, ir_after, 1'b0);
    chk({tag, " one_vld"}, vld_cnt - b_v, 1);
  endtask

  initial begin
    int b_v, b_s;
    int exp_ch [8] = '{1, 0, 4, 2, 3, 5, 7, 6};

    tick();
    chk("rst_outs", {IR_en, strt_cnv, chnnl, err_sat, err_vld, line_present}, 0);
    tick();
    rst = 1'b0;
    tick();

    // only ch6 (outer left) set, below threshold
    set_res(0, 0, 0, 0, 0, 0, 12'h010, 0);
    run_cycle("ch6_only", 11'h780, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("chseq%0d", i), ch_q[ch_q.size() - 8 + i], exp_ch[i]);

    // reset during WAIT of idx 3
    tick();
    b_v = vld_cnt; b_s = strt_cnt;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_strt("rst_mid", b_s + 4);
    tick();
    tick();
    chk("pre_rst_ir", IR_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {IR_en, strt_cnv, chnnl, err_vld, line_present}, 0);
    chk("rst_mid_err", err_sat, 11'h000);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_no_vld", vld_cnt, b_v);

    set_res(12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400);
    run_cycle("all_400", 11'h000, 1'b1, 1'b1, 1'b0);

    set_res(0, 12'hFFF, 0, 12'hFFF, 12'hFFF, 0, 0, 12'hFFF);
    run_cycle("right_max", 11'h3FF, 1'b1, 1'b1, 1'b0);
    set_res(12'hFFF, 0, 12'hFFF, 0, 0, 12'hFFF, 12'hFFF, 0);
    run_cycle("left_max", 11'h400, 1'b1, 1'b1, 1'b0);

    set_res(0, 12'h3FF, 0, 0, 0, 0, 0, 0);
    run_cycle("pos_1023", 11'h3FF, 1'b1, 1'b0, 1'b0);
    set_res(12'h400, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("neg_1024", 11'h400, 1'b1, 1'b0, 1'b0);
    set_res(12'h040, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("thres_eq", 11'h7C0, 1'b1, 1'b0, 1'b0);
    set_res(0, 0, 0, 0, 0, 0, 0, 12'h03F);
    run_cycle("ch7_3f", 11'h1F8, 1'b0, 1'b0, 1'b0);

    // slow A2D plus a stray cnv_cmplt while settling
    lat = 100;
    set_res(0, 12'h100, 12'h020, 0, 0, 0, 0, 0);
    run_cycle("slow_spur", 11'h0C0, 1'b1, 1'b0, 1'b1);
    lat = A2D_LAT;

    // go dropped at idx 2
    tick();
    b_v = vld_cnt; b_s = strt_cnt;
    go = 1'b1;
    wait_strt("drop", b_s + 3);
    go = 1'b0;
    wait_vld("drop", b_v + 1);
    chk("drop err_sat", err_sat, 11'h0C0);
    repeat (50) tick();
    chk("drop idle_strt", strt_cnt, b_s + 8);
    chk("drop one_vld", vld_cnt, b_v + 1);

    // go held: back-to-back cycles
    set_res(0, 0, 0, 0, 0, 0, 12'h010, 0);
    b_v = vld_cnt;
    go = 1'b1;
    wait_vld("b2b first", b_v + 1);
    b_s = strt_cnt;
    wait_strt("b2b second", b_s + 1);
    go = 1'b0;
    wait_vld("b2b second", b_v + 2);
    chk("b2b spacing", last_vld - prev_vld, LAT_EXP);
    chk("b2b err_sat", last_err, 11'h780);
    repeat (50) tick();
    chk("b2b idle", vld_cnt, b_v + 2);

    chk("chnnl_hold", hold_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
